cla16_pipe: RTL and testbench



---
 rtl/cla16_pipe_if.sv | 25 ++
 rtl/cla16_pipe.sv | 169 ++++++++++++++++
 tb/tb_cla16_pipe.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cla16_pipe_if.sv
// Operand/result bundle for the two-stage 16-bit carry-lookahead adder.
// The upstream stage drives the operands and stall; the adder drives the registered results.
interface cla16_pipe_if;
  localparam int unsigned DATA_W = 16;

  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              cin;
  logic              valid_in;
  logic              stall;
  logic [DATA_W-1:0] sum;
  logic              cout;
  logic              ofl;
  logic              valid_out;

  modport master (
    output a, b, cin, valid_in, stall,
    input  sum, cout, ofl, valid_out
  );

  modport slave (
    input  a, b, cin, valid_in, stall,
    output sum, cout, ofl, valid_out
  );
endinterface

// File: rtl/cla16_pipe.sv
// Two-stage pipelined 16-bit carry-lookahead adder: S1 captures operands and
// per-nibble group P/G, S2 resolves group carries and registers sum/cout/ofl.

// Group propagate/generate for one 4-bit nibble.
module cla4_pg (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gp,
  output logic       gg
);
  logic [3:0] p;
  logic [3:0] g;

  always_comb begin
    p  = a | b;
    g  = a & b;
    gp = &p;
    gg = g[3]
       | (p[3] & g[2])
       | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0]);
  end
endmodule

// Nibble sum using bit-level lookahead from the resolved group carry-in.
module cla4_sum (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  always_comb begin
    p    = a | b;
    g    = a & b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    s    = a ^ b ^ c;
  end
endmodule

module cla16_pipe (
  input  logic         clk,
  input  logic         rst,
  cla16_pipe_if.slave  bus
);
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned GRP_W   = 4;
  localparam int unsigned N_GRP   = DATA_W / GRP_W;

  // Stage 1 state
  logic [DATA_W-1:0] s1_a_q,   s1_a_d;
  logic [DATA_W-1:0] s1_b_q,   s1_b_d;
  logic              s1_cin_q, s1_cin_d;
  logic [N_GRP-1:0]  s1_gp_q,  s1_gp_d;
  logic [N_GRP-1:0]  s1_gg_q,  s1_gg_d;
  logic              s1_v_q,   s1_v_d;

  // Stage 2 state
  logic [DATA_W-1:0] sum_q,       sum_d;
  logic              cout_q,      cout_d;
  logic              ofl_q,       ofl_d;
  logic              valid_out_q, valid_out_d;

  logic [N_GRP-1:0]  gp_c;
  logic [N_GRP-1:0]  gg_c;
  logic [N_GRP:0]    gc_c;
  logic [DATA_W-1:0] sum_c;
  logic              ofl_c;

  for (genvar k = 0; k < N_GRP; k++) begin : g_grp
    cla4_pg u_pg (
      .a  (bus.a[GRP_W*k +: GRP_W]),
      .b  (bus.b[GRP_W*k +: GRP_W]),
      .gp (gp_c[k]),
      .gg (gg_c[k])
    );

    cla4_sum u_sum (
      .a  (s1_a_q[GRP_W*k +: GRP_W]),
      .b  (s1_b_q[GRP_W*k +: GRP_W]),
      .ci (gc_c[k]),
      .s  (sum_c[GRP_W*k +: GRP_W])
    );
  end

  // Group carry lookahead from registered group P/G; c4 chains off c3.
  always_comb begin
    gc_c[0] = s1_cin_q;
    gc_c[1] = s1_gg_q[0] | (s1_gp_q[0] & s1_cin_q);
    gc_c[2] = s1_gg_q[1]
            | (s1_gp_q[1] & s1_gg_q[0])
            | (s1_gp_q[1] & s1_gp_q[0] & s1_cin_q);
    gc_c[3] = s1_gg_q[2]
            | (s1_gp_q[2] & s1_gg_q[1])
            | (s1_gp_q[2] & s1_gp_q[1] & s1_gg_q[0])
            | (s1_gp_q[2] & s1_gp_q[1] & s1_gp_q[0] & s1_cin_q);
    gc_c[4] = s1_gg_q[3] | (s1_gp_q[3] & gc_c[3]);
    ofl_c   = (s1_a_q[DATA_W-1] == s1_b_q[DATA_W-1]) &&
              (sum_c[DATA_W-1]  != s1_a_q[DATA_W-1]);
  end

  // Next-state: everything holds under stall; data stages load only behind a valid.
  always_comb begin
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_cin_d    = s1_cin_q;
    s1_gp_d     = s1_gp_q;
    s1_gg_d     = s1_gg_q;
    s1_v_d      = s1_v_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ofl_d       = ofl_q;
    valid_out_d = valid_out_q;

    if (!bus.stall) begin
      s1_v_d      = bus.valid_in;
      valid_out_d = s1_v_q;
      if (bus.valid_in) begin
        s1_a_d   = bus.a;
        s1_b_d   = bus.b;
        s1_cin_d = bus.cin;
        s1_gp_d  = gp_c;
        s1_gg_d  = gg_c;
      end
      if (s1_v_q) begin
        sum_d  = sum_c;
        cout_d = gc_c[N_GRP];
        ofl_d  = ofl_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_cin_q    <= 1'b0;
      s1_gp_q     <= '0;
      s1_gg_q     <= '0;
      s1_v_q      <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ofl_q       <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_cin_q    <= s1_cin_d;
      s1_gp_q     <= s1_gp_d;
      s1_gg_q     <= s1_gg_d;
      s1_v_q      <= s1_v_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ofl_q       <= ofl_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ofl       = ofl_q;
  assign bus.valid_out = valid_out_q;
endmodule

// File: tb/tb_cla16_pipe.sv
// Bench for cla16_pipe: directed vector table, hand-built stall/bubble/reset
// sequences, and a randomized run against a transaction-level adder model.
module tb_cla16_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla16_pipe_if bus ();
  cla16_pipe dut (.clk(clk), .rst(rst), .bus(bus));

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ofl;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ofl;
  } vec_t;

  // Model: one pending result in flight plus the visible result.
  res_t m1_res, mo_res;
  logic m1_v, mo_v;

  function automatic res_t ref_add(input logic [15:0] a, input logic [15:0] b, input logic c);
    res_t        r;
    logic [16:0] w;
    shortint     sa, sb;
    int          s;
    w  = 17'(a) + 17'(b) + 17'(c);
    sa = shortint'(a);
    sb = shortint'(b);
    s  = int'(sa) + int'(sb) + int'(c);
    r.sum  = w[15:0];
    r.cout = w[16];
    r.ofl  = (s > 32767) || (s < -32768);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_out(input string name, input logic [15:0] s, input logic co,
                         input logic o, input logic v);
    chk({name, ".sum"},       32'(bus.sum),       32'(s));
    chk({name, ".cout"},      32'(bus.cout),      32'(co));
    chk({name, ".ofl"},       32'(bus.ofl),       32'(o));
    chk({name, ".valid_out"}, 32'(bus.valid_out), 32'(v));
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c, input logic v);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
    bus.valid_in = v;
  endtask

  // One clock: model follows the edge, outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m1_v = 1'b0; m1_res = '0; mo_v = 1'b0; mo_res = '0;
    end else if (!bus.stall) begin
      if (m1_v) mo_res = m1_res;
      mo_v = m1_v;
      if (bus.valid_in) m1_res = ref_add(bus.a, bus.b, bus.cin);
      m1_v = bus.valid_in;
    end
    @(negedge clk);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[1] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h0005, 16'hFFF8, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};

    // Reset held two cycles with live operands, then one idle cycle after release
    rst = 1'b1;
    bus.stall = 1'b0;
    drive(16'($urandom), 16'($urandom), 1'b1, 1'b1);
    step(); chk_out("rst0", 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(16'($urandom), 16'($urandom), 1'b0, 1'b1);
    step(); chk_out("rst1", 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    step(); chk_out("rst_post", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Back-to-back adds including full propagate with cin=1
    drive(16'h1234, 16'h4321, 1'b0, 1'b1);
    step(); chk("b2b_lat.valid_out", 32'(bus.valid_out), 32'd0);
    drive(16'hFFFF, 16'h0000, 1'b1, 1'b1);
    step(); chk_out("b2b0", 16'h5555, 1'b0, 1'b0, 1'b1);
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    step(); chk_out("b2b1", 16'h0000, 1'b1, 1'b0, 1'b1);
    step(); chk_out("b2b_idle", 16'h0000, 1'b1, 1'b0, 1'b0);

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
      step();
      drive(16'h0000, 16'h0000, 1'b0, 1'b0);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].ofl, 1'b1);
    end

    // Subtract form, then a 3-cycle stall with changing operands
    drive(16'h0005, 16'hFFF8, 1'b1, 1'b1);
    step();
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    step(); chk_out("sub", 16'hFFFE, 1'b0, 1'b0, 1'b1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(16'hAAAA + 16'(i), 16'h5555, 1'b1, 1'b1);
      step(); chk_out($sformatf("stall%0d", i), 16'hFFFE, 1'b0, 1'b0, 1'b1);
    end
    bus.stall = 1'b0;
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    step(); chk_out("stall_rel0", 16'hFFFE, 1'b0, 1'b0, 1'b0);
    step(); chk_out("stall_rel1", 16'hFFFE, 1'b0, 1'b0, 1'b0);

    // Bubble: valid, invalid, valid
    drive(16'h1111, 16'h2222, 1'b0, 1'b1);
    step();
    drive(16'h0F0F, 16'h0101, 1'b1, 1'b0);
    step(); chk_out("bub0", 16'h3333, 1'b0, 1'b0, 1'b1);
    drive(16'h4000, 16'h0001, 1'b0, 1'b1);
    step(); chk_out("bub1", 16'h3333, 1'b0, 1'b0, 1'b0);
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    step(); chk_out("bub2", 16'h4001, 1'b0, 1'b0, 1'b1);

    // Reset with two operations in flight
    drive(16'h0100, 16'h0200, 1'b0, 1'b1);
    step();
    drive(16'h0300, 16'h0400, 1'b0, 1'b1);
    step(); chk_out("mid_pre", 16'h0300, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    step(); chk_out("mid_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(); chk_out("mid_post", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Reset together with stall: reset wins
    drive(16'h1000, 16'h1000, 1'b0, 1'b1);
    step();
    step(); chk_out("rs_pre", 16'h2000, 1'b0, 1'b0, 1'b1);
    bus.stall = 1'b1;
    rst = 1'b1;
    step(); chk_out("rs_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    bus.stall = 1'b0;
    rst = 1'b0;
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    step(); chk_out("rs_post", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Randomized regression against the transaction model
    for (int i = 0; i < 12000; i++) begin
      rst       = ($urandom_range(199) == 0);
      bus.stall = ($urandom_range(3) == 0);
      drive(16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(9) < 7));
      step();
      chk_out($sformatf("rnd%0d", i), mo_res.sum, mo_res.cout, mo_res.ofl, mo_v);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
